// File: rtl/riscv_hazard_scoreboard.sv
// riscv_hazard_scoreboard: RAW forwarding from N post-EX stages, load-use
// stall, branch flush, and a single in-flight MDU op scoreboard.
// Optional feature macro: RISCV_HAZARD_PERF_EN (saturating perf counters).
module riscv_hazard_scoreboard #(
  parameter int MP_REGFILE_ADDR_WIDTH = 5,
  parameter int MP_NUM_FWD_STAGES     = 2,
  parameter int MP_FWD_SEL_WIDTH      = $clog2(MP_NUM_FWD_STAGES + 1)
) (
  input  logic                                             iclk,
  input  logic                                             irst_n,
  input  logic                                             ipc_src,
  input  logic [MP_REGFILE_ADDR_WIDTH-1:0]                 irs1_d,
  input  logic [MP_REGFILE_ADDR_WIDTH-1:0]                 irs2_d,
  input  logic [MP_REGFILE_ADDR_WIDTH-1:0]                 ird_d,
  input  logic                                             irs1_used_d,
  input  logic                                             irs2_used_d,
  input  logic                                             ird_wr_en_d,
  input  logic                                             imdu_d,
  input  logic [MP_REGFILE_ADDR_WIDTH-1:0]                 irs1_e,
  input  logic [MP_REGFILE_ADDR_WIDTH-1:0]                 irs2_e,
  input  logic [MP_REGFILE_ADDR_WIDTH-1:0]                 ird_e,
  input  logic                                             iload_e,
  input  logic                                             imdu_start,
  input  logic                                             imdu_done,
  input  logic [MP_NUM_FWD_STAGES*MP_REGFILE_ADDR_WIDTH-1:0] ird_stg,
  input  logic [MP_NUM_FWD_STAGES-1:0]                     ird_wr_en_stg,
  output logic [MP_FWD_SEL_WIDTH-1:0]                      oforward_alu_src_a,
  output logic [MP_FWD_SEL_WIDTH-1:0]                      oforward_alu_src_b,
  output logic                                             ostall_f,
  output logic                                             ostall_d,
  output logic                                             oflush_d,
  output logic                                             oflush_e,
  output logic                                             omdu_busy,
  output logic                                             omdu_err,
  output logic [31:0]                                      ocnt_stall_lw,
  output logic [31:0]                                      ocnt_stall_mdu,
  output logic [31:0]                                      ocnt_flush
);

  localparam int AW = MP_REGFILE_ADDR_WIDTH;
  localparam int N  = MP_NUM_FWD_STAGES;
  localparam int SW = MP_FWD_SEL_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   busy_rd, busy_rd_nxt;
  logic            err_nxt;
  logic            busy;
  logic            lw_stall, mdu_stall, stall;
  logic            rd_e_hit, busy_rd_hit;

  // Forward select: scan oldest to youngest so the youngest match wins.
  always_comb begin
    oforward_alu_src_a = '0;
    oforward_alu_src_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ird_wr_en_stg[N-1-i] && ird_stg[(N-1-i)*AW +: AW] == irs1_e && irs1_e != '0)
        oforward_alu_src_a = SW'(N - i);
      if (ird_wr_en_stg[N-1-i] && ird_stg[(N-1-i)*AW +: AW] == irs2_e && irs2_e != '0)
        oforward_alu_src_b = SW'(N - i);
    end
  end

  // Stall and flush decode against the EX destination and the MDU scoreboard.
  always_comb begin
    busy        = (state == BUSY);
    rd_e_hit    = (ird_e != '0) &&
                  ((irs1_used_d && irs1_d == ird_e) || (irs2_used_d && irs2_d == ird_e));
    busy_rd_hit = (busy_rd != '0) &&
                  ((irs1_used_d && irs1_d == busy_rd) || (irs2_used_d && irs2_d == busy_rd));
    lw_stall    = iload_e && rd_e_hit;
    mdu_stall   = (imdu_start && rd_e_hit) ||
                  (busy && busy_rd_hit) ||
                  (busy && ird_wr_en_d && ird_d == busy_rd) ||
                  (busy && imdu_d);
    stall       = lw_stall || mdu_stall;
    ostall_f    = stall && !ipc_src;
    ostall_d    = stall && !ipc_src;
    oflush_d    = ipc_src;
    oflush_e    = stall || ipc_src;
    omdu_busy   = busy;
  end

  // MDU tracker next state; start+done while busy retires then reissues.
  always_comb begin
    state_nxt   = state;
    busy_rd_nxt = busy_rd;
    err_nxt     = omdu_err;
    case (state)
      IDLE: begin
        if (imdu_done) err_nxt = 1'b1;
        if (imdu_start) begin
          state_nxt   = BUSY;
          busy_rd_nxt = ird_e;
        end
      end
      BUSY: begin
        if (imdu_start && imdu_done) begin
          busy_rd_nxt = ird_e;
        end else if (imdu_done) begin
          state_nxt = IDLE;
        end else if (imdu_start) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MDU tracker registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state    <= IDLE;
      busy_rd  <= '0;
      omdu_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_rd  <= busy_rd_nxt;
      omdu_err <= err_nxt;
    end
  end

`ifdef RISCV_HAZARD_PERF_EN
  // Saturating performance counters; MDU count excludes cycles already blamed on load-use.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ocnt_stall_lw  <= '0;
      ocnt_stall_mdu <= '0;
      ocnt_flush     <= '0;
    end else begin
      if (ostall_d && lw_stall && ocnt_stall_lw != '1)
        ocnt_stall_lw <= ocnt_stall_lw + 32'd1;
      if (ostall_d && mdu_stall && !lw_stall && ocnt_stall_mdu != '1)
        ocnt_stall_mdu <= ocnt_stall_mdu + 32'd1;
      if (ipc_src && ocnt_flush != '1)
        ocnt_flush <= ocnt_flush + 32'd1;
    end
  end
`else
  assign ocnt_stall_lw  = '0;
  assign ocnt_stall_mdu = '0;
  assign ocnt_flush     = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for riscv_hazard_scoreboard (N=3): expectations are queued
// while driving and popped/compared at the following negedge.
module tb_riscv_hazard_scoreboard;

  localparam int AW = 5;
  localparam int N  = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pc_src;
  logic [AW-1:0]   rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e;
  logic            rs1_used_d, rs2_used_d, rd_wr_en_d, mdu_d;
  logic            load_e, mdu_start, mdu_done;
  logic [N*AW-1:0] rd_stg;
  logic [N-1:0]    rd_wr_en_stg;
  logic [SW-1:0]   fwd_a, fwd_b;
  logic            stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_err;
  logic [31:0]     cnt_lw, cnt_mdu, cnt_flush;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];

  riscv_hazard_scoreboard #(
    .MP_REGFILE_ADDR_WIDTH(AW),
    .MP_NUM_FWD_STAGES(N),
    .MP_FWD_SEL_WIDTH(SW)
  ) dut (
    .iclk(clk), .irst_n(rst_n), .ipc_src(pc_src),
    .irs1_d(rs1_d), .irs2_d(rs2_d), .ird_d(rd_d),
    .irs1_used_d(rs1_used_d), .irs2_used_d(rs2_used_d), .ird_wr_en_d(rd_wr_en_d),
    .imdu_d(mdu_d), .irs1_e(rs1_e), .irs2_e(rs2_e), .ird_e(rd_e),
    .iload_e(load_e), .imdu_start(mdu_start), .imdu_done(mdu_done),
    .ird_stg(rd_stg), .ird_wr_en_stg(rd_wr_en_stg),
    .oforward_alu_src_a(fwd_a), .oforward_alu_src_b(fwd_b),
    .ostall_f(stall_f), .ostall_d(stall_d), .oflush_d(flush_d), .oflush_e(flush_e),
    .omdu_busy(mdu_busy), .omdu_err(mdu_err),
    .ocnt_stall_lw(cnt_lw), .ocnt_stall_mdu(cnt_mdu), .ocnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:  obs = 32'(fwd_a);
      1:  obs = 32'(fwd_b);
      2:  obs = 32'(stall_f);
      3:  obs = 32'(stall_d);
      4:  obs = 32'(flush_d);
      5:  obs = 32'(flush_e);
      6:  obs = 32'(mdu_busy);
      7:  obs = 32'(mdu_err);
      8:  obs = cnt_lw;
      9:  obs = cnt_mdu;
      10: obs = cnt_flush;
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic clear();
    pc_src = 0; rs1_d = '0; rs2_d = '0; rd_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    rs1_used_d = 0; rs2_used_d = 0; rd_wr_en_d = 0; mdu_d = 0;
    load_e = 0; mdu_start = 0; mdu_done = 0; rd_stg = '0; rd_wr_en_stg = '0;
  endtask

  // Advance to the drive point just after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic push_ctl(input string tag, input logic sf, input logic fd, input logic fe);
    push({tag, "_stall_f"}, 2, 32'(sf));
    push({tag, "_stall_d"}, 3, 32'(sf));
    push({tag, "_flush_d"}, 4, 32'(fd));
    push({tag, "_flush_e"}, 5, 32'(fe));
  endtask

  initial begin
    logic [31:0] exp_lw, exp_mdu, exp_fl;
`ifdef RISCV_HAZARD_PERF_EN
    exp_lw = 32'd3; exp_mdu = 32'd2; exp_fl = 32'd1;
`else
    exp_lw = 32'd0; exp_mdu = 32'd0; exp_fl = 32'd0;
`endif
    clear();
    rst_n = 0;
    push("rst_busy", 6, 0);
    push("rst_err", 7, 0);
    push("rst_cnt_lw", 8, 0);
    push("rst_cnt_mdu", 9, 0);
    push("rst_cnt_flush", 10, 0);
    push("rst_fwd_a", 0, 0);
    push_ctl("rst", 0, 0, 0);
    sample();
    rst_n = 1;

    // Forwarding: stages 1 and 3 write x5, stage 2 writes x3.
    next_cycle();
    rs1_e = 5'd5; rs2_e = 5'd3;
    rd_stg = {5'd5, 5'd3, 5'd5}; rd_wr_en_stg = 3'b111;
    push("fwd_a_youngest", 0, 1);
    push("fwd_b_stage2", 1, 2);
    sample();
    next_cycle();
    rd_wr_en_stg = 3'b110;
    push("fwd_a_stage3", 0, 3);
    sample();
    next_cycle();
    rs1_e = 5'd0; rd_stg = {5'd0, 5'd3, 5'd0}; rd_wr_en_stg = 3'b111;
    push("fwd_a_x0", 0, 0);
    sample();
    next_cycle();
    rs1_e = 5'd5; rs2_e = 5'd3; rd_stg = {5'd5, 5'd3, 5'd5}; rd_wr_en_stg = 3'b000;
    push("fwd_none_a", 0, 0);
    push("fwd_none_b", 1, 0);
    sample();

    // Load-use.
    next_cycle();
    clear();
    load_e = 1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1;
    push_ctl("lw", 1, 0, 1);
    sample();
    next_cycle();
    rs2_used_d = 0;
    push_ctl("lw_unused", 0, 0, 0);
    sample();
    next_cycle();
    rs2_used_d = 1; pc_src = 1;
    push_ctl("lw_redirect", 0, 1, 1);
    sample();

    // MDU RAW window through the done cycle.
    next_cycle();
    clear();
    mdu_start = 1; rd_e = 5'd9;
    push("mdu_issue_busy", 6, 0);
    push("mdu_issue_stall", 3, 0);
    sample();
    next_cycle();
    mdu_start = 0; rs1_d = 5'd9; rs1_used_d = 1;
    push("mdu_raw_stall", 3, 1);
    push("mdu_raw_busy", 6, 1);
    sample();
    next_cycle();
    mdu_done = 1;
    push("mdu_done_stall", 3, 1);
    push("mdu_done_busy", 6, 1);
    sample();
    next_cycle();
    mdu_done = 0;
    push("mdu_release_stall", 3, 0);
    push("mdu_release_busy", 6, 0);
    sample();

    // WAW, structural, start+done reissue, done while idle.
    next_cycle();
    clear();
    mdu_start = 1; rd_e = 5'd4;
    sample();
    next_cycle();
    clear();
    rd_d = 5'd4; rd_wr_en_d = 1;
    push("waw_stall", 3, 1);
    sample();
    next_cycle();
    clear();
    mdu_d = 1;
    push("struct_stall", 3, 1);
    sample();
    next_cycle();
    clear();
    push("busy_quiet_stall", 3, 0);
    push("busy_quiet_busy", 6, 1);
    sample();
    next_cycle();
    mdu_start = 1; mdu_done = 1; rd_e = 5'd6;
    push("reissue_err_pre", 7, 0);
    sample();
    next_cycle();
    clear();
    rs1_d = 5'd6; rs1_used_d = 1;
    push("reissue_raw_stall", 3, 1);
    push("reissue_busy", 6, 1);
    push("reissue_no_err", 7, 0);
    sample();
    next_cycle();
    clear();
    mdu_done = 1;
    push("retire_busy", 6, 1);
    sample();
    next_cycle();
    mdu_done = 1;
    push("idle_done_busy", 6, 0);
    push("idle_done_err_pre", 7, 0);
    sample();
    next_cycle();
    clear();
    push("idle_done_err", 7, 1);
    sample();
    next_cycle();
    push("err_sticky", 7, 1);
    sample();

    // Asynchronous reset in the middle of a BUSY window.
    next_cycle();
    mdu_start = 1; rd_e = 5'd3;
    sample();
    next_cycle();
    clear();
    rs1_d = 5'd3; rs1_used_d = 1;
    push("pre_rst_busy", 6, 1);
    sample();
    #2 rst_n = 0;
    #1;
    push("async_rst_busy", 6, 0);
    push("async_rst_err", 7, 0);
    push("async_rst_stall", 3, 0);
    drain();
    @(negedge clk);
    rst_n = 1;

    // Perf counters: 3 load-use cycles, 2 MDU-only cycles, 1 flush.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clear();
      load_e = 1; rd_e = 5'd7; rs2_d = 5'd7; rs2_used_d = 1;
      push("cnt_lw_stall", 3, 1);
      sample();
    end
    next_cycle();
    clear();
    mdu_start = 1; rd_e = 5'd9; rs1_d = 5'd9; rs1_used_d = 1;
    push("cnt_issue_stall", 3, 1);
    sample();
    next_cycle();
    mdu_start = 0; mdu_done = 1;
    push("cnt_raw_stall", 3, 1);
    sample();
    next_cycle();
    clear();
    pc_src = 1;
    push_ctl("cnt_flush_cycle", 0, 1, 1);
    sample();
    next_cycle();
    clear();
    push("cnt_lw", 8, exp_lw);
    push("cnt_mdu", 9, exp_mdu);
    push("cnt_flush", 10, exp_fl);
    push("cnt_end_busy", 6, 0);
    sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
